// File: rtl/dft_axi_regs_mc_if.sv
// AXI4-Lite bus bundle for the multi-channel DFT register front-end.
// The slave modport is the register block side; the master modport is the CPU side.
interface dft_axi_regs_mc_if #(
  parameter int ADDR_WIDTH = 24
);
  logic                  AWVALID;
  logic                  AWREADY;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [2:0]            AWPROT;
  logic                  WVALID;
  logic                  WREADY;
  logic [31:0]           WDATA;
  logic [3:0]            WSTRB;
  logic                  BVALID;
  logic                  BREADY;
  logic [1:0]            BRESP;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [2:0]            ARPROT;
  logic                  RVALID;
  logic                  RREADY;
  logic [31:0]           RDATA;
  logic [1:0]            RRESP;

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    input  ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    output ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/dft_axi_regs_mc.sv
// AXI4-Lite register front-end for DFT_CHANNELS DFT slices: control, ready IRQ,
// result readback and a write-through sample port towards external storage.
module dft_axi_regs_mc #(
  parameter int ADDR_WIDTH   = 24,
  parameter int DFT_CHANNELS = 4,
  parameter int DFT_SAMPLES  = 32,
  parameter int DFT_WIDTH    = 24,
  parameter int DFT_FRAC     = 8,
  localparam int IDX_W = $clog2(DFT_SAMPLES),
  localparam int CH_W  = (DFT_CHANNELS > 1) ? $clog2(DFT_CHANNELS) : 1
) (
  input  logic                              AXI_S_ACLK,
  input  logic                              AXI_S_ARESET,
  dft_axi_regs_mc_if.slave                  AXI_S,
  output logic [DFT_CHANNELS-1:0]           dft_reset,
  input  logic [DFT_CHANNELS-1:0]           dft_ready,
  output logic [IDX_W-1:0]                  dft_idx,
  input  logic [DFT_CHANNELS*DFT_WIDTH-1:0] dft_real,
  input  logic [DFT_CHANNELS*DFT_WIDTH-1:0] dft_imag,
  output logic                              src_we,
  output logic                              src_imag,
  output logic [CH_W-1:0]                   src_ch,
  output logic [IDX_W-1:0]                  src_idx,
  output logic [DFT_WIDTH-1:0]              src_data,
  output logic                              INTERRUPT
);

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] A_CMD       = 32'h000;
  localparam logic [31:0] A_READY     = 32'h004;
  localparam logic [31:0] A_IRQ_EN    = 32'h008;
  localparam logic [31:0] A_IRQ_STAT  = 32'h00C;
  localparam logic [31:0] A_CONFIG    = 32'h010;
  localparam logic [31:0] A_CHANNELS  = 32'h014;
  localparam logic [31:0] A_IDX       = 32'h020;

  logic                    awReady_q, wReady_q, awHeld_q, wHeld_q;
  logic [ADDR_WIDTH-1:0]   awAddr_q;
  logic [31:0]             wData_q;
  logic [3:0]              wStrb_q;
  logic                    bValid_q;
  logic [1:0]              bResp_q;
  logic                    arReady_q, arHeld_q, rPend_q, rValid_q;
  logic [ADDR_WIDTH-1:0]   arAddr_q;
  logic [31:0]             rData_q;
  logic [1:0]              rResp_q;
  logic [DFT_CHANNELS-1:0] cmd_q, cmd_d, irqEn_q, irqEn_d, irqStat_q, irqStat_d;
  logic [DFT_CHANNELS-1:0] readyPrev_q, wClr;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    irq_q;
  logic                    srcWe_q, srcImag_q;
  logic [CH_W-1:0]         srcCh_q;
  logic [IDX_W-1:0]        srcIdx_q;
  logic [DFT_WIDTH-1:0]    srcData_q;

  logic                    exec, wSample, wSrcOk;
  logic [1:0]              wResp;
  logic [31:0]             wa, ra, wMask, rdData;
  logic [1:0]              rdResp;
  logic [CH_W-1:0]         wCh;
  logic [IDX_W-1:0]        wIdx;
  logic                    resHit;
  logic signed [DFT_WIDTH-1:0] selReal, selImag;

  assign exec  = awHeld_q & wHeld_q;
  assign wa    = 32'(awAddr_q);
  assign ra    = 32'(arAddr_q);
  assign wMask = {{8{wStrb_q[3]}}, {8{wStrb_q[2]}}, {8{wStrb_q[1]}}, {8{wStrb_q[0]}}};
  assign wIdx  = wa[2 +: IDX_W];
  assign wCh   = wa[2+IDX_W +: CH_W];

  // Sample window: bit 23 set, bit 22 picks real/imag, everything above idx/ch must be zero.
  assign wSrcOk = (wa[31:23] == 9'd1) && (wa[1:0] == 2'b00) &&
                  ((wa[21:0] >> (2 + IDX_W + CH_W)) == 22'd0) &&
                  (32'(wCh) < DFT_CHANNELS);

  always_comb begin
    cmd_d   = cmd_q;
    irqEn_d = irqEn_q;
    idx_d   = idx_q;
    wClr    = '0;
    wSample = 1'b0;
    wResp   = RESP_SLVERR;
    if (exec) begin
      case (wa)
        A_CMD: begin
          cmd_d = (cmd_q & ~wMask[DFT_CHANNELS-1:0]) | (wData_q[DFT_CHANNELS-1:0] & wMask[DFT_CHANNELS-1:0]);
          wResp = RESP_OKAY;
        end
        A_IRQ_EN: begin
          irqEn_d = (irqEn_q & ~wMask[DFT_CHANNELS-1:0]) | (wData_q[DFT_CHANNELS-1:0] & wMask[DFT_CHANNELS-1:0]);
          wResp   = RESP_OKAY;
        end
        A_IRQ_STAT: begin
          wClr  = wData_q[DFT_CHANNELS-1:0] & wMask[DFT_CHANNELS-1:0];
          wResp = RESP_OKAY;
        end
        A_IDX: begin
          idx_d = (idx_q & ~wMask[IDX_W-1:0]) | (wData_q[IDX_W-1:0] & wMask[IDX_W-1:0]);
          wResp = RESP_OKAY;
        end
        default: begin
          if (wSrcOk && (wStrb_q == 4'hF)) begin
            wSample = 1'b1;
            wResp   = RESP_OKAY;
          end
        end
      endcase
    end
  end

  // A new ready edge in the same cycle as a W1C clear keeps the bit set.
  assign irqStat_d = (irqStat_q & ~wClr) | (dft_ready & ~readyPrev_q);

  always_ff @(posedge AXI_S_ACLK or posedge AXI_S_ARESET) begin
    if (AXI_S_ARESET) begin
      awReady_q <= 1'b1;
      wReady_q  <= 1'b1;
      awHeld_q  <= 1'b0;
      wHeld_q   <= 1'b0;
      awAddr_q  <= '0;
      wData_q   <= '0;
      wStrb_q   <= '0;
      bValid_q  <= 1'b0;
      bResp_q   <= RESP_OKAY;
    end else begin
      if (AXI_S.AWVALID && awReady_q) begin
        awHeld_q  <= 1'b1;
        awAddr_q  <= AXI_S.AWADDR;
        awReady_q <= 1'b0;
      end
      if (AXI_S.WVALID && wReady_q) begin
        wHeld_q  <= 1'b1;
        wData_q  <= AXI_S.WDATA;
        wStrb_q  <= AXI_S.WSTRB;
        wReady_q <= 1'b0;
      end
      if (exec) begin
        awHeld_q <= 1'b0;
        wHeld_q  <= 1'b0;
        bValid_q <= 1'b1;
        bResp_q  <= wResp;
      end
      if (bValid_q && AXI_S.BREADY) begin
        bValid_q  <= 1'b0;
        awReady_q <= 1'b1;
        wReady_q  <= 1'b1;
      end
    end
  end

  always_ff @(posedge AXI_S_ACLK or posedge AXI_S_ARESET) begin
    if (AXI_S_ARESET) begin
      cmd_q       <= '1;
      irqEn_q     <= '0;
      irqStat_q   <= '0;
      readyPrev_q <= '0;
      idx_q       <= '0;
      irq_q       <= 1'b0;
      srcWe_q     <= 1'b0;
      srcImag_q   <= 1'b0;
      srcCh_q     <= '0;
      srcIdx_q    <= '0;
      srcData_q   <= '0;
    end else begin
      cmd_q       <= cmd_d;
      irqEn_q     <= irqEn_d;
      irqStat_q   <= irqStat_d;
      readyPrev_q <= dft_ready;
      idx_q       <= idx_d;
      irq_q       <= |(irqStat_q & irqEn_q);
      srcWe_q     <= wSample;
      if (wSample) begin
        srcImag_q <= wa[22];
        srcCh_q   <= wCh;
        srcIdx_q  <= wIdx;
        srcData_q <= wData_q[DFT_WIDTH-1:0];
      end
    end
  end

  // Result window: 0x100 + 0x10*n, offset 0 is real and offset 4 is imag.
  assign resHit = (ra[31:8] == 24'd1) && ((ra[3:0] == 4'h0) || (ra[3:0] == 4'h4)) &&
                  (32'(ra[7:4]) < DFT_CHANNELS);

  always_comb begin
    selReal = '0;
    selImag = '0;
    for (int c = 0; c < DFT_CHANNELS; c++) begin
      if (ra[7:4] == 4'(c)) begin
        selReal = dft_real[c*DFT_WIDTH +: DFT_WIDTH];
        selImag = dft_imag[c*DFT_WIDTH +: DFT_WIDTH];
      end
    end
    rdData = '0;
    rdResp = RESP_OKAY;
    case (ra)
      A_CMD:      rdData = 32'(cmd_q);
      A_READY:    rdData = 32'(dft_ready);
      A_IRQ_EN:   rdData = 32'(irqEn_q);
      A_IRQ_STAT: rdData = 32'(irqStat_q);
      A_CONFIG:   rdData = {16'(DFT_SAMPLES), 8'(DFT_WIDTH), 8'(DFT_FRAC)};
      A_CHANNELS: rdData = 32'(DFT_CHANNELS);
      A_IDX:      rdData = 32'(idx_q);
      default: begin
        if (resHit) rdData = ra[2] ? 32'(selImag) : 32'(selReal);
        else        rdResp = RESP_SLVERR;
      end
    endcase
  end

  always_ff @(posedge AXI_S_ACLK or posedge AXI_S_ARESET) begin
    if (AXI_S_ARESET) begin
      arReady_q <= 1'b1;
      arHeld_q  <= 1'b0;
      arAddr_q  <= '0;
      rPend_q   <= 1'b0;
      rValid_q  <= 1'b0;
      rData_q   <= '0;
      rResp_q   <= RESP_OKAY;
    end else begin
      rPend_q <= 1'b0;
      if (AXI_S.ARVALID && arReady_q) begin
        arHeld_q  <= 1'b1;
        arAddr_q  <= AXI_S.ARADDR;
        arReady_q <= 1'b0;
      end
      if (arHeld_q) begin
        arHeld_q <= 1'b0;
        rPend_q  <= 1'b1;
        rData_q  <= rdData;
        rResp_q  <= rdResp;
      end
      if (rPend_q) rValid_q <= 1'b1;
      if (rValid_q && AXI_S.RREADY) begin
        rValid_q  <= 1'b0;
        arReady_q <= 1'b1;
      end
    end
  end

  assign AXI_S.AWREADY = awReady_q;
  assign AXI_S.WREADY  = wReady_q;
  assign AXI_S.BVALID  = bValid_q;
  assign AXI_S.BRESP   = bResp_q;
  assign AXI_S.ARREADY = arReady_q;
  assign AXI_S.RVALID  = rValid_q;
  assign AXI_S.RDATA   = rData_q;
  assign AXI_S.RRESP   = rResp_q;
  assign dft_reset     = cmd_q;
  assign dft_idx       = idx_q;
  assign INTERRUPT     = irq_q;
  assign src_we        = srcWe_q;
  assign src_imag      = srcImag_q;
  assign src_ch        = srcCh_q;
  assign src_idx       = srcIdx_q;
  assign src_data      = srcData_q;

  logic unusedBits;
  assign unusedBits = ^{AXI_S.AWPROT, AXI_S.ARPROT, wData_q};

endmodule

// File: tb/tb_dft_axi_regs_mc.sv
// Self-checking bench for dft_axi_regs_mc: per-feature tasks with a queue-based
// scoreboard of expected B/R responses popped as the DUT answers.
module tb_dft_axi_regs_mc;

  localparam int AW = 24;
  localparam int CH = 4;
  localparam int NS = 32;
  localparam int W  = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CH-1:0]   dftReset;
  logic [CH-1:0]   dftReady;
  logic [4:0]      dftIdx;
  logic [CH*W-1:0] dftReal;
  logic [CH*W-1:0] dftImag;
  logic            srcWe, srcImag;
  logic [1:0]      srcCh;
  logic [4:0]      srcIdx;
  logic [W-1:0]    srcData;
  logic            irq;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rExp_t;

  rExp_t      rExpQ[$];
  logic [1:0] bExpQ[$];

  logic        seenImag;
  logic [1:0]  seenCh;
  logic [4:0]  seenIdx;
  logic [W-1:0] seenData;

  dft_axi_regs_mc_if #(.ADDR_WIDTH(AW)) bus ();

  dft_axi_regs_mc #(
    .ADDR_WIDTH(AW), .DFT_CHANNELS(CH), .DFT_SAMPLES(NS), .DFT_WIDTH(W), .DFT_FRAC(8)
  ) dut (
    .AXI_S_ACLK  (clk),
    .AXI_S_ARESET(rst),
    .AXI_S       (bus),
    .dft_reset   (dftReset),
    .dft_ready   (dftReady),
    .dft_idx     (dftIdx),
    .dft_real    (dftReal),
    .dft_imag    (dftImag),
    .src_we      (srcWe),
    .src_imag    (srcImag),
    .src_ch      (srcCh),
    .src_idx     (srcIdx),
    .src_data    (srcData),
    .INTERRUPT   (irq)
  );

  always #5 clk = ~clk;

  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int awDelay, input int wDelay,
                         output logic [1:0] resp, output int bBeats, output int srcPulses);
    int cyc = 0;
    int post = 0;
    bit awDone = 0;
    bit wDone = 0;
    bit awHs, wHs;
    resp = 2'bxx;
    bBeats = 0;
    srcPulses = 0;
    bus.BREADY = 1'b1;
    while (cyc < 40 && post < 4) begin
      bus.AWADDR  = addr[AW-1:0];
      bus.AWVALID = !awDone && cyc >= awDelay;
      bus.WDATA   = data;
      bus.WSTRB   = strb;
      bus.WVALID  = !wDone && cyc >= wDelay;
      awHs = bus.AWVALID && bus.AWREADY;
      wHs  = bus.WVALID && bus.WREADY;
      @(posedge clk); #1;
      if (awHs) awDone = 1;
      if (wHs) wDone = 1;
      if (srcWe) begin
        srcPulses++;
        seenImag = srcImag; seenCh = srcCh; seenIdx = srcIdx; seenData = srcData;
      end
      if (bus.BVALID) begin
        bBeats++;
        resp = bus.BRESP;
      end
      if (bBeats > 0) post++;
      cyc++;
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
    end
  endtask

  task automatic doRead(input logic [31:0] addr, input int hold,
                        output logic [31:0] data, output logic [1:0] resp,
                        output int lat, output bit stable);
    int cyc = 0;
    bit hs = 0;
    bus.ARADDR  = addr[AW-1:0];
    bus.ARVALID = 1'b1;
    bus.RREADY  = 1'b0;
    while (!hs && cyc < 20) begin
      hs = bus.ARREADY;
      @(posedge clk); #1;
      cyc++;
    end
    bus.ARVALID = 1'b0;
    lat = 0;
    while (!bus.RVALID && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    data = bus.RDATA;
    resp = bus.RRESP;
    stable = bus.RVALID;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!bus.RVALID || bus.RDATA !== data || bus.RRESP !== resp) stable = 0;
    end
    bus.RREADY = 1'b1;
    @(posedge clk); #1;
    bus.RREADY = 1'b0;
    if (bus.RVALID) stable = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    nChecks++; if (bus.AWREADY !== 1'b1) begin nFails++; $display("[TB] FAIL reset_awready got=%b exp=1", bus.AWREADY); end
    nChecks++; if (bus.WREADY !== 1'b1) begin nFails++; $display("[TB] FAIL reset_wready got=%b exp=1", bus.WREADY); end
    nChecks++; if (bus.ARREADY !== 1'b1) begin nFails++; $display("[TB] FAIL reset_arready got=%b exp=1", bus.ARREADY); end
    nChecks++; if (bus.BVALID !== 1'b0 || bus.RVALID !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valids got=%b%b exp=00", bus.BVALID, bus.RVALID); end
    nChecks++; if (dftReset !== 4'hF) begin nFails++; $display("[TB] FAIL reset_dft_reset got=%h exp=f", dftReset); end
    nChecks++; if (dftIdx !== 5'd0 || srcWe !== 1'b0 || irq !== 1'b0) begin nFails++; $display("[TB] FAIL reset_misc got idx=%0d we=%b irq=%b exp 0/0/0", dftIdx, srcWe, irq); end
  endtask

  task automatic test_config();
    logic [31:0] addrs[4] = '{32'h010, 32'h014, 32'h000, 32'h008};
    logic [31:0] exps[4]  = '{32'h00201808, 32'h4, 32'hF, 32'h0};
    logic [31:0] d; logic [1:0] r; int lat; bit st; rExp_t e;
    for (int i = 0; i < 4; i++) begin
      rExpQ.push_back('{data: exps[i], resp: 2'b00});
      doRead(addrs[i], 0, d, r, lat, st);
      e = rExpQ.pop_front();
      nChecks++;
      if (d !== e.data || r !== e.resp) begin
        nFails++; $display("[TB] FAIL config_read_%h got=%h/%b exp=%h/%b", addrs[i], d, r, e.data, e.resp);
      end
    end
  endtask

  task automatic test_idx_write();
    logic [1:0] r, e; int beats, pulses;
    bExpQ.push_back(2'b00);
    doWrite(32'h020, 32'h5, 4'hF, 0, 3, r, beats, pulses);
    e = bExpQ.pop_front();
    nChecks++; if (r !== e || beats != 1) begin nFails++; $display("[TB] FAIL idx_bresp got=%b beats=%0d exp=%b beats=1", r, beats, e); end
    nChecks++; if (dftIdx !== 5'd5) begin nFails++; $display("[TB] FAIL idx_value got=%0d exp=5", dftIdx); end
    nChecks++; if (pulses != 0) begin nFails++; $display("[TB] FAIL idx_no_src got=%0d exp=0", pulses); end
    bExpQ.push_back(2'b00);
    doWrite(32'h020, 32'h1F, 4'h0, 0, 0, r, beats, pulses);
    e = bExpQ.pop_front();
    nChecks++; if (r !== e || dftIdx !== 5'd5) begin nFails++; $display("[TB] FAIL idx_nostrobe got=%b/%0d exp=%b/5", r, dftIdx, e); end
  endtask

  task automatic test_src_write();
    logic [1:0] r, e; int beats, pulses;
    bExpQ.push_back(2'b00);
    doWrite(32'h800000 + (((1 << 5) | 7) << 2), 32'h123456, 4'hF, 2, 0, r, beats, pulses);
    e = bExpQ.pop_front();
    nChecks++; if (r !== e || pulses != 1) begin nFails++; $display("[TB] FAIL src_real_resp got=%b pulses=%0d exp=%b pulses=1", r, pulses, e); end
    nChecks++;
    if (seenImag !== 1'b0 || seenCh !== 2'd1 || seenIdx !== 5'd7 || seenData !== 24'h123456) begin
      nFails++; $display("[TB] FAIL src_real_fields got=%b/%0d/%0d/%h exp=0/1/7/123456", seenImag, seenCh, seenIdx, seenData);
    end
    bExpQ.push_back(2'b00);
    doWrite(32'hC00000 + (((3 << 5) | 31) << 2), 32'hFFABCDEF, 4'hF, 0, 0, r, beats, pulses);
    e = bExpQ.pop_front();
    nChecks++;
    if (r !== e || pulses != 1 || seenImag !== 1'b1 || seenCh !== 2'd3 || seenIdx !== 5'd31 || seenData !== 24'hABCDEF) begin
      nFails++; $display("[TB] FAIL src_imag got=%b/%0d/%b/%0d/%0d/%h exp=00/1/1/3/31/abcdef", r, pulses, seenImag, seenCh, seenIdx, seenData);
    end
  endtask

  task automatic test_irq();
    logic [1:0] r; int beats, pulses; logic [31:0] d; int lat; bit st; rExp_t e;
    doWrite(32'h000, 32'h0, 4'hF, 0, 0, r, beats, pulses);
    nChecks++; if (dftReset !== 4'h0) begin nFails++; $display("[TB] FAIL irq_cmd_clear got=%h exp=0", dftReset); end
    doWrite(32'h008, 32'h4, 4'hF, 0, 0, r, beats, pulses);
    dftReady[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nChecks++; if (irq !== 1'b1) begin nFails++; $display("[TB] FAIL irq_raise got=%b exp=1", irq); end
    rExpQ.push_back('{data: 32'h4, resp: 2'b00});
    doRead(32'h00C, 0, d, r, lat, st);
    e = rExpQ.pop_front();
    nChecks++; if (d !== e.data || r !== e.resp) begin nFails++; $display("[TB] FAIL irq_stat_read got=%h/%b exp=%h/%b", d, r, e.data, e.resp); end
    doWrite(32'h00C, 32'h4, 4'hF, 0, 0, r, beats, pulses);
    nChecks++; if (irq !== 1'b0) begin nFails++; $display("[TB] FAIL irq_w1c got=%b exp=0", irq); end
    rExpQ.push_back('{data: 32'h0, resp: 2'b00});
    doRead(32'h00C, 0, d, r, lat, st);
    e = rExpQ.pop_front();
    nChecks++; if (d !== e.data || r !== e.resp) begin nFails++; $display("[TB] FAIL irq_stat_cleared got=%h/%b exp=%h/%b", d, r, e.data, e.resp); end
  endtask

  task automatic test_read_result();
    logic [31:0] d; logic [1:0] r; int lat; bit st; rExp_t e;
    dftImag[1*W +: W] = 24'h800000;
    dftReal[3*W +: W] = 24'h7FFFFF;
    rExpQ.push_back('{data: 32'hFF800000, resp: 2'b00});
    doRead(32'h114, 4, d, r, lat, st);
    e = rExpQ.pop_front();
    nChecks++; if (d !== e.data || r !== e.resp) begin nFails++; $display("[TB] FAIL result_imag1 got=%h/%b exp=%h/%b", d, r, e.data, e.resp); end
    nChecks++; if (lat != 2) begin nFails++; $display("[TB] FAIL result_latency got=%0d exp=2", lat); end
    nChecks++; if (!st) begin nFails++; $display("[TB] FAIL result_hold got=%b exp=1", st); end
    rExpQ.push_back('{data: 32'h007FFFFF, resp: 2'b00});
    doRead(32'h130, 0, d, r, lat, st);
    e = rExpQ.pop_front();
    nChecks++; if (d !== e.data || r !== e.resp) begin nFails++; $display("[TB] FAIL result_real3 got=%h/%b exp=%h/%b", d, r, e.data, e.resp); end
  endtask

  task automatic test_errors();
    logic [31:0] rAddrs[3] = '{32'h0F0, 32'h800000, 32'h108};
    logic [31:0] wAddrs[3] = '{32'h800380, 32'h800000, 32'h004};
    logic [3:0]  wStrbs[3] = '{4'hF, 4'h3, 4'hF};
    logic [31:0] d; logic [1:0] r, eb; int lat, beats, pulses; bit st; rExp_t e;
    for (int i = 0; i < 3; i++) begin
      rExpQ.push_back('{data: 32'h0, resp: 2'b10});
      doRead(rAddrs[i], 0, d, r, lat, st);
      e = rExpQ.pop_front();
      nChecks++; if (d !== e.data || r !== e.resp) begin nFails++; $display("[TB] FAIL err_read_%h got=%h/%b exp=%h/%b", rAddrs[i], d, r, e.data, e.resp); end
    end
    for (int i = 0; i < 3; i++) begin
      bExpQ.push_back(2'b10);
      doWrite(wAddrs[i], 32'h15, wStrbs[i], 0, 0, r, beats, pulses);
      eb = bExpQ.pop_front();
      nChecks++; if (r !== eb || pulses != 0 || beats != 1) begin nFails++; $display("[TB] FAIL err_write_%h got=%b pulses=%0d beats=%0d exp=%b/0/1", wAddrs[i], r, pulses, beats, eb); end
    end
    nChecks++; if (dftIdx !== 5'd5 || dftReset !== 4'h0) begin nFails++; $display("[TB] FAIL err_no_effect got=%0d/%h exp=5/0", dftIdx, dftReset); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] r; int beats, pulses; logic [31:0] d; int lat; bit st; rExp_t e;
    doWrite(32'h008, 32'hF, 4'hF, 0, 0, r, beats, pulses);
    doWrite(32'h008, 32'hA, 4'hF, 1, 0, r, beats, pulses);
    rExpQ.push_back('{data: 32'hA, resp: 2'b00});
    doRead(32'h008, 1, d, r, lat, st);
    e = rExpQ.pop_front();
    nChecks++; if (d !== e.data || r !== e.resp) begin nFails++; $display("[TB] FAIL b2b_irq_en got=%h/%b exp=%h/%b", d, r, e.data, e.resp); end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    int stray = 0;
    bit hs = 0;
    logic [31:0] d; logic [1:0] r; int lat; bit st; rExp_t e;
    bus.ARADDR = 24'h010; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
    while (!hs && cyc < 20) begin hs = bus.ARREADY; @(posedge clk); #1; cyc++; end
    bus.ARVALID = 1'b0;
    cyc = 0;
    while (!bus.RVALID && cyc < 10) begin @(posedge clk); #1; cyc++; end
    bus.AWADDR = 24'h020; bus.AWVALID = 1'b1;
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    nChecks++; if (bus.RVALID !== 1'b1 || bus.AWREADY !== 1'b0) begin nFails++; $display("[TB] FAIL mid_setup got rvalid=%b awready=%b exp=1/0", bus.RVALID, bus.AWREADY); end
    #2 rst = 1'b1;
    #1;
    nChecks++;
    if (bus.AWREADY !== 1'b1 || bus.WREADY !== 1'b1 || bus.ARREADY !== 1'b1 || bus.RVALID !== 1'b0 || bus.BVALID !== 1'b0) begin
      nFails++; $display("[TB] FAIL mid_bus got aw=%b w=%b ar=%b rv=%b bv=%b exp=1/1/1/0/0", bus.AWREADY, bus.WREADY, bus.ARREADY, bus.RVALID, bus.BVALID);
    end
    nChecks++;
    if (dftReset !== 4'hF || dftIdx !== 5'd0 || irq !== 1'b0 || srcWe !== 1'b0) begin
      nFails++; $display("[TB] FAIL mid_regs got rst=%h idx=%0d irq=%b we=%b exp=f/0/0/0", dftReset, dftIdx, irq, srcWe);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.BREADY = 1'b1;
    bus.WDATA = 32'h3; bus.WSTRB = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.BVALID || bus.RVALID) stray++;
    end
    nChecks++; if (stray != 0) begin nFails++; $display("[TB] FAIL mid_no_stale got=%0d exp=0", stray); end
    rExpQ.push_back('{data: 32'hF, resp: 2'b00});
    doRead(32'h000, 0, d, r, lat, st);
    e = rExpQ.pop_front();
    nChecks++; if (d !== e.data || r !== e.resp) begin nFails++; $display("[TB] FAIL mid_cmd_read got=%h/%b exp=%h/%b", d, r, e.data, e.resp); end
  endtask

  initial begin
    bus.AWVALID = 0; bus.AWADDR = '0; bus.AWPROT = '0;
    bus.WVALID = 0; bus.WDATA = '0; bus.WSTRB = '0; bus.BREADY = 0;
    bus.ARVALID = 0; bus.ARADDR = '0; bus.ARPROT = '0; bus.RREADY = 0;
    dftReady = '0; dftReal = '0; dftImag = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_config();
    test_idx_write();
    test_src_write();
    test_irq();
    test_read_result();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/dft_axi_regs_mc.md
Name: dft_axi_regs_mc

Overview:
AXI4-Lite slave register front-end for a multi-channel DFT engine; it generalises the single-slice register block to DFT_CHANNELS slices. It provides per-channel reset/ready, a maskable ready interrupt with W1C status, and per-channel result readback. Source samples are not stored locally: the block emits a sample write port to external storage. AW and W channels are accepted independently, and unmapped accesses return SLVERR.

Parameters:
ADDR_WIDTH, 24, AXI address width
DFT_CHANNELS, 4, number of DFT slices, 1..16
DFT_SAMPLES, 32, samples per channel, power of two, 2..65536
DFT_WIDTH, 24, sample/result width, <=32
DFT_FRAC, 8, fraction bits, reported only
Derived: IDX_W=$clog2(DFT_SAMPLES); CH_W=max(1,$clog2(DFT_CHANNELS))

Ports:
AXI_S_ACLK  in  1  sole clock
AXI_S_ARESET  in  1  reset, asynchronous, active-high
AXI_S_AWVALID/AWREADY/AWADDR[ADDR_WIDTH]/AWPROT[3]  in/out/in/in  write address channel
AXI_S_WVALID/WREADY/WDATA[32]/WSTRB[4]  in/out/in/in  write data channel
AXI_S_BVALID/BREADY/BRESP[2]  out/in/out  write response channel
AXI_S_ARVALID/ARREADY/ARADDR[ADDR_WIDTH]/ARPROT[3]  in/out/in/in  read address channel
AXI_S_RVALID/RREADY/RDATA[32]/RRESP[2]  out/in/out/out  read data channel
dft_reset  out  DFT_CHANNELS  per-slice reset
dft_ready  in  DFT_CHANNELS  per-slice ready
dft_idx  out  IDX_W  output index shared by all slices
dft_real, dft_imag  in  DFT_CHANNELS*DFT_WIDTH  slice results, channel n at [n*W +: W]
src_we  out  1  one-cycle sample write strobe
src_imag  out  1  0=real, 1=imag array
src_ch  out  CH_W  target channel
src_idx  out  IDX_W  target sample
src_data  out  DFT_WIDTH  WDATA[DFT_WIDTH-1:0]
INTERRUPT  out  1  level interrupt

Behaviour:
- Register map (word-aligned; all other addresses unmapped):
  - 0x000 CMD_STAT: rw [CH-1:0] dft_reset, reset value all ones.
  - 0x004 READY: ro, dft_ready.
  - 0x008 IRQ_EN: rw, reset 0.
  - 0x00C IRQ_STAT: W1C; bit n is set on a rising edge of dft_ready[n]. If a set and a clear hit the same bit in the same cycle, set wins.
  - 0x010 CONFIG: ro {SAMPLES[15:0],WIDTH[7:0],FRAC[7:0]}.
  - 0x014 CHANNELS: ro.
  - 0x020 DFT_IDX: rw, reset 0.
  - 0x100+0x10*n: DFT_REAL[n], ro; 0x104+0x10*n: DFT_IMAG[n], ro. Both are sign-extended to 32 bits.
  - 0x800000 SRC_REAL, 0xC00000 SRC_IMAG: wo. idx=addr[2+:IDX_W], ch=addr[2+IDX_W+:CH_W]. Higher bits must be 0 and ch must be < DFT_CHANNELS; otherwise the access is unmapped.
- Reset: every READY output is 0 except AWREADY=ARREADY=WREADY=1. BVALID=RVALID=0. dft_reset all ones. IRQ_EN=IRQ_STAT=0. dft_idx=0. src_we=0. INTERRUPT=0. The dft_ready edge detector resets to 0.
- Write path:
  - AW and W are latched independently in either order or in the same cycle. The corresponding READY drops after each capture.
  - In the cycle after both are held, the write executes and BVALID rises.
  - After the BVALID&BREADY handshake, AWREADY and WREADY return to 1 the next cycle. Only one write is outstanding.
- WSTRB:
  - rw registers update bytes only where WSTRB is set.
  - W1C applies only on strobed bytes.
  - Sample writes require WSTRB==4'hF; any other strobe is SLVERR with no src_we.
- BRESP: 00 OKAY, 10 SLVERR for unmapped/ro targets. Writes to ro/unmapped targets have no effect.
- src_we pulses exactly one cycle, coincident with the execute cycle; src_* are valid only while src_we=1.
- Read path:
  - AR capture drops ARREADY.
  - Next cycle: data and response are registered.
  - The cycle after that: RVALID=1, held with stable RDATA until RREADY.
  - ARREADY returns to 1 the cycle after the handshake. Latency from AR handshake to RVALID is 2 cycles.
- RRESP: SLVERR with RDATA=0 for unmapped or SRC addresses.
- The read and write paths are independent and may run concurrently.
- INTERRUPT is registered: |(IRQ_STAT & IRQ_EN), one cycle after either changes.
- Reset asserted mid-transaction aborts immediately; no B/R response is issued for the aborted transaction.

Test Plan:
- AW then W 3 cycles later to 0x020 with WDATA=5 -> dft_idx=5, BRESP=00, exactly one B beat.
- W before AW to 0x800000+((1<<5|7)<<2) with WDATA=0x123456 -> src_we one cycle, ch=1, idx=7, src_imag=0, src_data=0x123456.
- Write 0x000=0, enable IRQ_EN=0x4, raise dft_ready[2] -> IRQ_STAT=0x4 and INTERRUPT=1; write 0x00C=0x4 -> INTERRUPT=0 a cycle later.
- Read 0x114 with dft_imag[1]=0x800000 (W=24) -> RDATA=0xFF800000 two cycles after AR, held while RREADY=0 for 4 cycles.
- Read 0x0F0; write ch=7 with CHANNELS=4; write WSTRB=0x3 to a SRC address -> SLVERR on each, no src_we, no register change.
- Assert reset with RVALID=1 and a pending AW -> all outputs return to reset values asynchronously; CMD_STAT reads 0xF afterward.
